// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants and types for the multiplier issue controller.
package mul_issue_ctrl_pkg;

    // Bus widths used by the execute pipes and the multiplier wrapper.
    localparam int ES_TO_MUL_BUS_MD = 69;
    localparam int MUL_TO_ES_BUS_MD = 33;

    // Request / issue bus layout. Fields are right-aligned and the two top
    // bits [68:67] are reserved padding:
    //   [66] valid (request) or use_mul (issue)
    //   [65] use_high
    //   [64] is_unsigned
    //   [63:32] x
    //   [31:0]  y
    localparam int REQ_VALID_BIT = 66;
    localparam int REQ_HIGH_BIT  = 65;
    localparam int REQ_UNS_BIT   = 64;

    // Result bus layout: {mul_result[31:0], mul_ok}.
    localparam int MUL_OK_BIT = 0;

    // Slot encoding for owner/last/grant: 1 means slot 1, 0 means slot 2.
    // Reset value 0 therefore reads as "slot 2 served last".
    localparam logic SLOT1 = 1'b1;

    typedef enum logic [1:0] {
        MIC_IDLE  = 2'd0,
        MIC_ISSUE = 2'd1,
        MIC_WAIT  = 2'd2,
        MIC_DONE  = 2'd3
    } mic_state_t;

    // Extracts the valid flag from a pipe request bus.
    function automatic logic req_valid(input logic [ES_TO_MUL_BUS_MD-1:0] bus);
        return bus[REQ_VALID_BIT];
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_arb.sv
// Two-way round-robin pick between the execute pipes' multiply requests.
module mul_req_arb
    import mul_issue_ctrl_pkg::*;
(
    input  logic valid1,
    input  logic valid2,
    input  logic last,
    output logic grant,
    output logic any
);

    // Slot 1 wins when it is alone, or when both ask and slot 1 was not served last.
    always_comb begin
        any   = valid1 | valid2;
        grant = ~SLOT1;
        if (valid1 && (!valid2 || (last != SLOT1))) begin
            grant = SLOT1;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Execute-stage front end for the shared multiplier: arbitrates the two pipes,
// holds the winning operands on the multiplier bus, captures the product and
// returns a one-cycle done pulse to the requesting pipe.
//
// Handshake: a pipe holds its request (valid=1) stable while its stall is 1.
// stall = valid & ~done, so the cycle in which done pulses is the transfer
// cycle; the pipe advances at that clock edge and may present a new request
// in the very next cycle.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [ES_TO_MUL_BUS_MD-1:0] es_req_bus1,
    input  logic [ES_TO_MUL_BUS_MD-1:0] es_req_bus2,
    output logic [ES_TO_MUL_BUS_MD-1:0] es_to_mul_bus,
    input  logic [MUL_TO_ES_BUS_MD-1:0] mul_to_es_bus,
    output logic                        stall1,
    output logic                        stall2,
    output logic                        done1,
    output logic                        done2,
    output logic [31:0]                 result,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [1:0]                  state_dbg
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Last WAIT count value before the timeout fires; reaching TIMEOUT
    // after the increment abandons the operation.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mic_state_t        state;
    logic              owner;
    logic              last;
    logic              use_high_q;
    logic              is_unsigned_q;
    logic [31:0]       x_q;
    logic [31:0]       y_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              valid1;
    logic              valid2;
    logic              grant;
    logic              any;
    logic [REQ_HIGH_BIT:0] sel_ops;
    logic              mul_ok;
    logic [31:0]       mul_result;
    logic              active;
    logic              unused_req_bits;

    assign valid1     = req_valid(es_req_bus1);
    assign valid2     = req_valid(es_req_bus2);
    assign mul_ok     = mul_to_es_bus[MUL_OK_BIT];
    assign mul_result = mul_to_es_bus[MUL_TO_ES_BUS_MD-1:1];
    assign sel_ops    = (grant == SLOT1) ? es_req_bus1[REQ_HIGH_BIT:0]
                                         : es_req_bus2[REQ_HIGH_BIT:0];
    // Reserved padding bits of the request buses carry nothing.
    assign unused_req_bits = ^{es_req_bus1[68:67], es_req_bus2[68:67]};

    mul_req_arb u_arb (
        .valid1 (valid1),
        .valid2 (valid2),
        .last   (last),
        .grant  (grant),
        .any    (any)
    );

    // Controller FSM with operand latch, wait counter, result capture and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= MIC_IDLE;
            owner         <= 1'b0;
            last          <= 1'b0;
            use_high_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            wait_cnt      <= '0;
            result        <= '0;
            timeout_err   <= 1'b0;
        end else if (flush) begin
            // Kill whatever is in flight; history in last is kept.
            state    <= MIC_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                MIC_IDLE: begin
                    if (any) begin
                        owner         <= grant;
                        use_high_q    <= sel_ops[REQ_HIGH_BIT];
                        is_unsigned_q <= sel_ops[REQ_UNS_BIT];
                        x_q           <= sel_ops[63:32];
                        y_q           <= sel_ops[31:0];
                        wait_cnt      <= '0;
                        state         <= MIC_ISSUE;
                    end
                end
                MIC_ISSUE: begin
                    state <= MIC_WAIT;
                end
                MIC_WAIT: begin
                    if (mul_ok) begin
                        result <= mul_result;
                        state  <= MIC_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt    <= wait_cnt + CNT_W'(1);
                        result      <= '0;
                        timeout_err <= 1'b1;
                        state       <= MIC_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                MIC_DONE: begin
                    last  <= owner;
                    state <= MIC_IDLE;
                end
                default: begin
                    state <= MIC_IDLE;
                end
            endcase
        end
    end

    // Multiplier request bus: operands only while issuing/waiting and never during a flush.
    always_comb begin
        active        = (state == MIC_ISSUE) || (state == MIC_WAIT);
        es_to_mul_bus = '0;
        if (active && !flush) begin
            es_to_mul_bus[REQ_VALID_BIT:0] = {1'b1, use_high_q, is_unsigned_q, x_q, y_q};
        end
    end

    // Done pulses, stalls and status derived from the registered state.
    always_comb begin
        done1     = (state == MIC_DONE) && (owner == SLOT1) && !flush;
        done2     = (state == MIC_DONE) && (owner != SLOT1) && !flush;
        stall1    = valid1 & ~done1;
        stall2    = valid2 & ~done2;
        busy      = (state != MIC_IDLE);
        state_dbg = state;
    end

endmodule
